// File: rtl/bec_pkg.sv
// Shared constants, state encoding and status codes for the BEC ladder sequencer.
package bec_pkg;

    localparam int unsigned BEC_WIDTH = 163;
    localparam int unsigned NUM_SLOTS = 6;

    localparam logic [2:0] SLOT_W1     = 3'd0;
    localparam logic [2:0] SLOT_Z1     = 3'd1;
    localparam logic [2:0] SLOT_W2     = 3'd2;
    localparam logic [2:0] SLOT_Z2     = 3'd3;
    localparam logic [2:0] SLOT_INV_W0 = 3'd4;
    localparam logic [2:0] SLOT_D      = 3'd5;

    localparam logic [5:0] MASK_FULL = 6'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADV,
        S_DONE,
        S_ERR
    } bec_state_e;

    typedef enum logic [3:0] {
        ST_EMPTY   = 4'h0,
        ST_PARTIAL = 4'h1,
        ST_READY   = 4'h2,
        ST_RUN     = 4'h4,
        ST_DONE    = 4'h8,
        ST_ERR     = 4'hE
    } bec_status_e;

    function automatic logic [3:0] status_for(input bec_state_e s, input logic [5:0] mask);
        logic [3:0] st;
        case (s)
            S_IDLE: begin
                if (mask == '0)             st = ST_EMPTY;
                else if (mask == MASK_FULL) st = ST_READY;
                else                        st = ST_PARTIAL;
            end
            S_DONE:  st = ST_DONE;
            S_ERR:   st = ST_ERR;
            default: st = ST_RUN;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/bec_operand_bank.sv
// Six operand registers with a per-slot valid mask; supports load, mask clear
// and a four-word ladder update from the step datapath.
module bec_operand_bank
    import bec_pkg::*;
#(
    parameter int unsigned WIDTH = BEC_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [2:0]       slot_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
    input  logic             upd_i,
    input  logic [WIDTH-1:0] res_w1_i,
    input  logic [WIDTH-1:0] res_z1_i,
    input  logic [WIDTH-1:0] res_w2_i,
    input  logic [WIDTH-1:0] res_z2_i,
    output logic [WIDTH-1:0] w1_o,
    output logic [WIDTH-1:0] z1_o,
    output logic [WIDTH-1:0] w2_o,
    output logic [WIDTH-1:0] z2_o,
    output logic [WIDTH-1:0] inv_w0_o,
    output logic [WIDTH-1:0] d_o,
    output logic [5:0]       valid_o,
    output logic [5:0]       valid_nxt_o
);

    logic [WIDTH-1:0] slot_q [NUM_SLOTS];
    logic [WIDTH-1:0] slot_d [NUM_SLOTS];
    logic [5:0]       valid_q, valid_d;

    // Clear precedes capture so a load into a finished run starts a fresh mask.
    always_comb begin
        slot_d  = slot_q;
        valid_d = clear_i ? '0 : valid_q;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (load_i && (slot_i == 3'(i))) begin
                slot_d[i]  = data_i;
                valid_d[i] = 1'b1;
            end
        end
        if (upd_i) begin
            slot_d[SLOT_W1] = res_w1_i;
            slot_d[SLOT_Z1] = res_z1_i;
            slot_d[SLOT_W2] = res_w2_i;
            slot_d[SLOT_Z2] = res_z2_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= slot_d[i];
            end
            valid_q <= valid_d;
        end
    end

    assign w1_o        = slot_q[SLOT_W1];
    assign z1_o        = slot_q[SLOT_Z1];
    assign w2_o        = slot_q[SLOT_W2];
    assign z2_o        = slot_q[SLOT_Z2];
    assign inv_w0_o    = slot_q[SLOT_INV_W0];
    assign d_o         = slot_q[SLOT_D];
    assign valid_o     = valid_q;
    assign valid_nxt_o = valid_d;

endmodule

// File: rtl/bec_ladder_sequencer.sv
// Montgomery-ladder sequencer: captures operands, runs KEY_BITS ladder steps
// over a start/done handshake with an external datapath and returns results.
module bec_ladder_sequencer
    import bec_pkg::*;
#(
    parameter int unsigned WIDTH    = BEC_WIDTH,
    parameter int unsigned KEY_BITS = 163,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             load_data,
    input  logic [2:0]       load_status,
    input  logic [WIDTH-1:0] data_in,
    input  logic             master_ena_proc,
    input  logic             ki,
    output logic             next_key,
    output logic             slv_done,
    output logic [3:0]       becStatus,
    output logic [WIDTH-1:0] data_out,
    output logic             step_start,
    output logic             step_swap,
    input  logic             step_done,
    output logic [WIDTH-1:0] op_w1,
    output logic [WIDTH-1:0] op_z1,
    output logic [WIDTH-1:0] op_w2,
    output logic [WIDTH-1:0] op_z2,
    output logic [WIDTH-1:0] op_inv_w0,
    output logic [WIDTH-1:0] op_d,
    input  logic [WIDTH-1:0] res_w1,
    input  logic [WIDTH-1:0] res_z1,
    input  logic [WIDTH-1:0] res_w2,
    input  logic [WIDTH-1:0] res_z2
);

    bec_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_start_q, next_key_q, slv_done_q;
    logic [3:0]       status_q;
    logic [5:0]       valid, valid_nxt;
    logic             bank_load, bank_clear, bank_upd, last_step;

    bec_operand_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .load_i     (bank_load),
        .slot_i     (load_status),
        .data_i     (data_in),
        .clear_i    (bank_clear),
        .upd_i      (bank_upd),
        .res_w1_i   (res_w1),
        .res_z1_i   (res_z1),
        .res_w2_i   (res_w2),
        .res_z2_i   (res_z2),
        .w1_o       (op_w1),
        .z1_o       (op_z1),
        .w2_o       (op_w2),
        .z2_o       (op_z2),
        .inv_w0_o   (op_inv_w0),
        .d_o        (op_d),
        .valid_o    (valid),
        .valid_nxt_o(valid_nxt)
    );

    // Results are captured on the accepted step_done edge, so they are
    // already in the working registers during ADV.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bank_load  = 1'b0;
        bank_clear = 1'b0;
        bank_upd   = 1'b0;
        last_step  = (cnt_q == CNT_W'(KEY_BITS - 1));
        case (state_q)
            S_IDLE: begin
                bank_load = load_data;
                if (master_ena_proc) begin
                    if (valid == MASK_FULL) begin
                        state_d = S_ISSUE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ISSUE: state_d = master_ena_proc ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!master_ena_proc) begin
                    state_d = S_IDLE;
                end else if (step_done) begin
                    state_d  = S_ADV;
                    bank_upd = 1'b1;
                end
            end
            S_ADV: begin
                if (!master_ena_proc) begin
                    state_d = S_IDLE;
                end else if (last_step) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (load_data) begin
                    bank_clear = 1'b1;
                    bank_load  = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_ERR:   if (!master_ena_proc) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            step_start_q <= 1'b0;
            next_key_q   <= 1'b0;
            slv_done_q   <= 1'b0;
            status_q     <= ST_EMPTY;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_start_q <= (state_d == S_ISSUE);
            next_key_q   <= (state_d == S_ADV);
            slv_done_q   <= (state_d == S_DONE);
            status_q     <= status_for(state_d, valid_nxt);
        end
    end

    // ki is sampled live in ISSUE so the bit advanced after ADV is used.
    assign step_start = step_start_q;
    assign step_swap  = step_start_q & ki;
    assign next_key   = next_key_q;
    assign slv_done   = slv_done_q;
    assign becStatus  = status_q;
    assign data_out   = (state_q != S_DONE)       ? '0    :
                        (load_status == SLOT_Z1)  ? op_z1 : op_w1;

endmodule

// File: doc/bec_ladder_sequencer.md
Name: bec_ladder_sequencer

Overview:
Downstream neighbour of the LA-facing BEC controller. Captures the six GF(2^163) operands it pushes (w1, z1, w2, z2, inv_w0, d). On master_ena_proc, runs KEY_BITS Montgomery-ladder steps, one key bit per step, using an external ladder-step datapath over a start/done handshake. Returns slv_done, becStatus and the result words (w1/z1) back to the controller.

Parameters:
WIDTH, 163, field element width
KEY_BITS, 163, ladder steps per run
CNT_W, 8, step counter width; must satisfy 2^CNT_W >= KEY_BITS

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
load_data  in  1  one-cycle strobe: capture data_in into operand slot load_status
load_status  in  3  slot select: 0 w1, 1 z1, 2 w2, 3 z2, 4 inv_w0, 5 d; 6/7 invalid; in DONE also selects result word
data_in  in  WIDTH  operand word from controller
master_ena_proc  in  1  run enable (level)
ki  in  1  current key bit, LSB-first; advances the cycle after next_key
next_key  out  1  one-cycle pulse requesting the next key bit
slv_done  out  1  run complete (level)
becStatus  out  4  status code
data_out  out  WIDTH  result word to controller
step_start  out  1  one-cycle pulse: datapath begins one ladder step
step_swap  out  1  key bit for this step, valid with step_start
step_done  in  1  one-cycle pulse: res_* valid
op_w1, op_z1, op_w2, op_z2  out  WIDTH each  working ladder registers
op_inv_w0, op_d  out  WIDTH each  constant operands
res_w1, res_z1, res_w2, res_z2  in  WIDTH each  step results

Behaviour:
- Clock/reset: one clock, wb_clk_i. Reset wb_rst_i is asynchronous and active-high.
- Reset values:
  - all operand registers 0; valid mask 6'b0; counter 0
  - state IDLE
  - next_key, step_start, step_swap, slv_done = 0; becStatus 4'h0; data_out 0
- States: IDLE, ISSUE, WAIT, ADV, DONE, ERR.
- Loading (IDLE and DONE only):
  - load_data with load_status 0..5 writes data_in into that slot and sets its mask bit.
  - Slots 6/7 are ignored.
  - Rewriting a slot overwrites it; last write wins.
  - In DONE, a load_data strobe first clears the mask, then captures, then moves to IDLE.
  - load_data in ISSUE/WAIT/ADV/ERR is ignored.
- becStatus in IDLE:
  - 4'h0 when mask == 0
  - 4'h1 when mask is partial
  - 4'h2 when mask == 6'h3F
- IDLE exits:
  - master_ena_proc=1 with mask==6'h3F → ISSUE, counter ← 0.
  - master_ena_proc=1 with mask incomplete → ERR (becStatus 4'hE). Leaves ERR to IDLE when master_ena_proc=0.
- ISSUE:
  - step_start=1 for exactly 1 cycle, step_swap=ki; becStatus 4'h4; → WAIT.
  - step_done in this cycle is ignored.
- WAIT: holds until step_done=1 → ADV.
- ADV (1 cycle):
  - op_w1/z1/w2/z2 ← res_*; next_key=1 for this cycle.
  - If counter==KEY_BITS-1 → DONE, else counter+1 → ISSUE.
  - The following ISSUE samples the already-advanced ki.
- Step cycle cost: minimum 3 cycles per step (ISSUE, WAIT with same-cycle step_done, ADV). Latency of a run is KEY_BITS*(2+datapath wait) cycles.
- DONE:
  - slv_done=1 (held); becStatus 4'h8.
  - data_out = op_z1 when load_status==3'b001, else op_w1.
  - master_ena_proc may drop without effect.
- data_out is 0 in every state other than DONE.
- Abort: master_ena_proc=0 while in ISSUE/WAIT/ADV → IDLE next cycle.
  - No further step_start or next_key.
  - A pending or later step_done is ignored.
  - Working registers keep their last values; mask is retained.
- op_inv_w0 and op_d are static between loads.
- Reset mid-run: immediate return to reset values, including the mask.

Decomposition:
- Package bec_pkg:
  - BEC_WIDTH = 163
  - slot index constants SLOT_W1..SLOT_D
  - state enum
  - becStatus codes ST_EMPTY, ST_PARTIAL, ST_READY, ST_RUN, ST_DONE, ST_ERR
- Sub-module bec_operand_bank: six WIDTH registers plus valid mask, with load/clear/ladder-update ports. The sequencer FSM and counter stay in the top.

Test Plan:
- Load slots 0..5 with 163'h1..163'h6 via six strobes → becStatus 1 after the first strobe, 2 after the sixth; op_inv_w0=5, op_d=6.
- Load only slots 0..4, raise master_ena_proc → ERR, becStatus 4'hE, no step_start. Drop enable → IDLE, becStatus 1.
- Full load, KEY_BITS=4, ki pattern 1,0,1,1, datapath model returns res_w1=step index, step_done 2 cycles after start:
  - exactly 4 step_start pulses with step_swap 1,0,1,1
  - 4 next_key pulses, one cycle after each step_done
  - slv_done=1, becStatus 8, data_out=3 (load_status=0) or res_z1 of step 3 (load_status=1)
- step_done asserted in the same cycle as step_start → ignored; the step completes only on the next step_done.
- Drop master_ena_proc during WAIT of step 2 → IDLE next cycle, a late step_done produces no next_key, op_w1 keeps the step-1 result, mask still 6'h3F.
- Assert wb_rst_i asynchronously mid-WAIT → all outputs 0, becStatus 0, mask 0; a subsequent load works normally.
